// File: rtl/pc16_seq.sv
// rtl/pc16_seq.sv - 16-bit program counter with optional return-address stack
//
// Purpose:
//   Registered program counter for the CPU datapath, driving the instruction
//   memory address bus. Each rising edge executes one command, chosen by
//   priority clr > load > call > ret > inc > hold.
//
// Configuration macro:
//   PC16_STACK_EN - when defined, a STACK_DEPTH-entry return-address stack
//                   is built and call/ret are honoured. When undefined,
//                   call/ret are ignored and the stack flags are constants
//                   (empty=1, full=0, err=0).
//
// Parameters:
//   WIDTH        - PC and data width in bits
//   RESET_VECTOR - PC value after rst_n or clr
//   STACK_DEPTH  - return-stack entries, power of 2, at least 2
//
// Ports:
//   clk          in   1      rising-edge clock
//   rst_n        in   1      asynchronous active-low reset
//   clr          in   1      synchronous restart to RESET_VECTOR
//   load         in   1      jump: pc <= d
//   call         in   1      push pc+1, then pc <= d
//   ret          in   1      pc <= top of stack, then pop
//   inc          in   1      pc <= pc+1 (wraps)
//   d            in   WIDTH  jump/call target
//   pc           out  WIDTH  current program counter (registered)
//   stack_empty  out  1      no entries on stack
//   stack_full   out  1      STACK_DEPTH entries on stack
//   stack_err    out  1      sticky overflow/underflow flag

module pc16_seq #(
    parameter int              WIDTH        = 16,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int              STACK_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic             call,
    input  logic             ret,
    input  logic             inc,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] pc,
    output logic             stack_empty,
    output logic             stack_full,
    output logic             stack_err
);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_pc_next;
    logic [WIDTH-1:0] w_pc_plus1;

    // Natural WIDTH-bit truncation gives the mod 2^WIDTH wrap.
    assign w_pc_plus1 = r_pc + WIDTH'(1);

`ifdef PC16_STACK_EN

    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam int SP_W  = IDX_W + 1;

    logic [WIDTH-1:0] r_stack [STACK_DEPTH];
    logic [SP_W-1:0]  r_sp;
    logic             r_err;

    logic             w_empty;
    logic             w_full;
    logic             w_do_call;
    logic             w_do_ret;
    logic             w_push;
    logic             w_pop;
    logic [SP_W-1:0]  w_sp_m1;
    logic [IDX_W-1:0] w_push_idx;
    logic [IDX_W-1:0] w_top_idx;

    assign w_empty    = (r_sp == '0);
    assign w_full     = (r_sp == SP_W'(STACK_DEPTH));
    assign w_sp_m1    = r_sp - SP_W'(1);
    assign w_push_idx = r_sp[IDX_W-1:0];
    assign w_top_idx  = w_sp_m1[IDX_W-1:0];

    // call/ret win only when nothing of higher priority is asserted.
    assign w_do_call  = !clr && !load && call;
    assign w_do_ret   = !clr && !load && !call && ret;
    assign w_push     = w_do_call && !w_full;
    assign w_pop      = w_do_ret && !w_empty;

    always_comb begin
        w_pc_next = r_pc;
        if (clr) begin
            w_pc_next = RESET_VECTOR;
        end else if (load) begin
            w_pc_next = d;
        end else if (call) begin
            // Target is taken even when the push is dropped on overflow.
            w_pc_next = d;
        end else if (ret) begin
            // Underflow leaves pc unchanged.
            if (!w_empty) begin
                w_pc_next = r_stack[w_top_idx];
            end
        end else if (inc) begin
            w_pc_next = w_pc_plus1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sp  <= '0;
            r_err <= 1'b0;
        end else if (clr) begin
            r_sp  <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_sp <= r_sp + SP_W'(1);
            end else if (w_pop) begin
                r_sp <= w_sp_m1;
            end
            if ((w_do_call && w_full) || (w_do_ret && w_empty)) begin
                r_err <= 1'b1;
            end
        end
    end

    // Entries above sp are dead data, so storage needs no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[w_push_idx] <= w_pc_plus1;
        end
    end

    assign stack_empty = w_empty;
    assign stack_full  = w_full;
    assign stack_err   = r_err;

`else

    logic w_unused_cmds;

    assign w_unused_cmds = call ^ ret;

    always_comb begin
        w_pc_next = r_pc;
        if (clr) begin
            w_pc_next = RESET_VECTOR;
        end else if (load) begin
            w_pc_next = d;
        end else if (inc) begin
            w_pc_next = w_pc_plus1;
        end
    end

    assign stack_empty = 1'b1;
    assign stack_full  = 1'b0;
    assign stack_err   = 1'b0;

`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_VECTOR;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign pc = r_pc;

endmodule

// File: tb/tb_pc16_seq.sv
// tb/tb_pc16_seq.sv - directed self-checking bench for pc16_seq

module tb_pc16_seq;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        load;
    logic        call;
    logic        ret;
    logic        inc;
    logic [15:0] d;
    logic [15:0] pc;
    logic        stack_empty;
    logic        stack_full;
    logic        stack_err;

    int n_pass;
    int n_total;

    pc16_seq #(
        .WIDTH        (16),
        .RESET_VECTOR (16'h0000),
        .STACK_DEPTH  (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .load        (load),
        .call        (call),
        .ret         (ret),
        .inc         (inc),
        .d           (d),
        .pc          (pc),
        .stack_empty (stack_empty),
        .stack_full  (stack_full),
        .stack_err   (stack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_flags(input string tag, input logic e, input logic f, input logic r);
        chk({tag, ".empty"}, {15'h0, stack_empty}, {15'h0, e});
        chk({tag, ".full"},  {15'h0, stack_full},  {15'h0, f});
        chk({tag, ".err"},   {15'h0, stack_err},   {15'h0, r});
    endtask

    // Drive one command set, let one rising edge execute it, sample 1 ns later.
    task automatic cyc(input logic c_clr, input logic c_load, input logic c_call,
                       input logic c_ret, input logic c_inc, input logic [15:0] c_d);
        clr  = c_clr;
        load = c_load;
        call = c_call;
        ret  = c_ret;
        inc  = c_inc;
        d    = c_d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n = 1'b0;
        clr = 1'b0; load = 1'b0; call = 1'b0; ret = 1'b0; inc = 1'b0; d = 16'h0;

        #12;
        chk("reset.pc", pc, 16'h0000);
        chk_flags("reset", 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Asynchronous reset with no clock edge.
        cyc(0, 1, 0, 0, 0, 16'h1234);
        chk("load.1234", pc, 16'h1234);
        clr = 1'b0; load = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_rst.pc", pc, 16'h0000);
        #1;
        rst_n = 1'b1;

        // Increment wrap.
        cyc(0, 1, 0, 0, 0, 16'hFFFE);
        chk("load.fffe", pc, 16'hFFFE);
        cyc(0, 0, 0, 0, 1, 16'h0000);
        chk("inc.ffff", pc, 16'hFFFF);
        cyc(0, 0, 0, 0, 1, 16'h0000);
        chk("inc.wrap", pc, 16'h0000);

        // Priority clr > load > inc, and hold.
        cyc(0, 1, 0, 0, 1, 16'h00A0);
        chk("load_over_inc", pc, 16'h00A0);
        cyc(0, 0, 0, 0, 0, 16'h5555);
        chk("hold", pc, 16'h00A0);
        cyc(1, 1, 0, 0, 0, 16'h1234);
        chk("clr_over_load", pc, 16'h0000);

`ifdef PC16_STACK_EN
        // Basic call/return.
        cyc(0, 1, 0, 0, 0, 16'h0010);
        cyc(0, 0, 1, 0, 0, 16'h0200);
        chk("call.pc", pc, 16'h0200);
        chk_flags("call", 1'b0, 1'b0, 1'b0);
        cyc(0, 0, 0, 1, 1, 16'h0000);
        chk("ret.pc", pc, 16'h0011);
        chk_flags("ret", 1'b1, 1'b0, 1'b0);

        // load beats call: no push.
        cyc(0, 1, 1, 0, 0, 16'h0777);
        chk("load_over_call.pc", pc, 16'h0777);
        chk_flags("load_over_call", 1'b1, 1'b0, 1'b0);

        // Fill, overflow, drain, underflow.
        cyc(0, 1, 0, 0, 0, 16'h0100);
        cyc(0, 0, 1, 0, 0, 16'h0200);
        cyc(0, 0, 1, 0, 0, 16'h0300);
        cyc(0, 0, 1, 0, 0, 16'h0400);
        chk_flags("call3", 1'b0, 1'b0, 1'b0);
        cyc(0, 0, 1, 1, 1, 16'h0500);
        chk("call4.pc", pc, 16'h0500);
        chk_flags("call4", 1'b0, 1'b1, 1'b0);
        cyc(0, 0, 1, 0, 0, 16'h0600);
        chk("call5.pc", pc, 16'h0600);
        chk_flags("call5", 1'b0, 1'b1, 1'b1);
        cyc(0, 0, 0, 1, 0, 16'h0000);
        chk("ret1.pc", pc, 16'h0401);
        chk_flags("ret1", 1'b0, 1'b0, 1'b1);
        cyc(0, 0, 0, 1, 0, 16'h0000);
        chk("ret2.pc", pc, 16'h0301);
        cyc(0, 0, 0, 1, 0, 16'h0000);
        chk("ret3.pc", pc, 16'h0201);
        cyc(0, 0, 0, 1, 0, 16'h0000);
        chk("ret4.pc", pc, 16'h0101);
        chk_flags("ret4", 1'b1, 1'b0, 1'b1);
        cyc(0, 0, 0, 1, 1, 16'h0000);
        chk("ret5.hold", pc, 16'h0101);
        chk_flags("ret5", 1'b1, 1'b0, 1'b1);

        // Underflow flag alone, then clr clears it.
        cyc(1, 0, 0, 0, 0, 16'h0000);
        chk("clr.pc", pc, 16'h0000);
        chk_flags("clr", 1'b1, 1'b0, 1'b0);
        cyc(0, 0, 0, 1, 0, 16'h0000);
        chk("underflow.pc", pc, 16'h0000);
        chk_flags("underflow", 1'b1, 1'b0, 1'b1);
        cyc(0, 0, 0, 0, 0, 16'h0000);
        chk_flags("err_sticky", 1'b1, 1'b0, 1'b1);
`else
        // call/ret ignored without the stack.
        cyc(0, 1, 0, 0, 0, 16'h0050);
        cyc(0, 0, 1, 0, 0, 16'h0300);
        chk("nostack.call", pc, 16'h0050);
        chk_flags("nostack.call", 1'b1, 1'b0, 1'b0);
        cyc(0, 0, 1, 0, 1, 16'h0300);
        chk("nostack.call_inc", pc, 16'h0051);
        cyc(0, 0, 0, 1, 0, 16'h0000);
        chk("nostack.ret", pc, 16'h0051);
        cyc(0, 0, 1, 1, 1, 16'h0300);
        chk("nostack.all_inc", pc, 16'h0052);
        chk_flags("nostack.end", 1'b1, 1'b0, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
